// File: rtl/inst_align_pkg.sv
// Shared types and helpers for the instruction realigner (package align_pkg).
package align_pkg;

  typedef enum logic [1:0] {
    LO       = 2'd0,
    HI       = 2'd1,
    STRADDLE = 2'd2
  } align_state_t;

  localparam int HALF_BYTES = 2;

  // A half-word whose low two bits are not 2'b11 is a complete RVC instruction.
  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/inst_align.sv
// Instruction realigner: splits aligned 32-bit fetch words into 16/32-bit instructions.
// Compressed support (HI/STRADDLE states, hold registers) is built only with INST_ALIGN_RVC_EN.
module inst_align
  import align_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            compressed
);

`ifdef INST_ALIGN_RVC_EN
  align_state_t    state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [15:0]     w_lo, w_hi;
  logic [XLEN-1:0] pc_hi;

  assign w_lo  = fetch_data[15:0];
  assign w_hi  = fetch_data[31:16];
  assign pc_hi = fetch_pc + XLEN'(HALF_BYTES);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_pc_d   = hold_pc_q;
    out_valid   = 1'b0;
    fetch_ready = 1'b0;
    out_inst    = fetch_data;
    out_pc      = fetch_pc;
    compressed  = 1'b0;
    if (redirect) begin
      state_d   = redirect_pc[1] ? HI : LO;
      hold_d    = '0;
      hold_pc_d = '0;
    end else if (fetch_valid && !rst) begin
      case (state_q)
        LO: begin
          out_valid = 1'b1;
          if (is_rvc(w_lo)) begin
            out_inst   = {16'h0, w_lo};
            compressed = 1'b1;
            if (out_ready) state_d = HI;
          end else begin
            fetch_ready = out_ready;
          end
        end
        HI: begin
          if (is_rvc(w_hi)) begin
            out_valid  = 1'b1;
            out_inst   = {16'h0, w_hi};
            out_pc     = pc_hi;
            compressed = 1'b1;
            if (out_ready) begin
              fetch_ready = 1'b1;
              state_d     = LO;
            end
          end else begin
            // Upper half starts a 32-bit instruction: park it and fetch the next word.
            fetch_ready = 1'b1;
            hold_d      = w_hi;
            hold_pc_d   = pc_hi;
            state_d     = STRADDLE;
          end
        end
        STRADDLE: begin
          out_valid = 1'b1;
          out_inst  = {w_lo, hold_q};
          out_pc    = hold_pc_q;
          if (out_ready) state_d = HI;
        end
        default: state_d = LO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LO;
      hold_q    <= '0;
      hold_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, redirect_pc};

  // Without RVC every fetch word is exactly one instruction.
  assign out_valid   = fetch_valid & ~redirect & ~rst;
  assign fetch_ready = out_valid & out_ready;
  assign out_inst    = fetch_data;
  assign out_pc      = fetch_pc;
  assign compressed  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_align.sv
// Self-checking bench for inst_align: directed cases plus randomized streams vs a halfword-stream model.
module tb_inst_align;
  localparam int XLEN = 64;
  localparam int NH   = 64;
  localparam int NW   = NH / 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fetch_valid = 1'b0;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc = '0;
  logic [31:0]     fetch_data = '0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            compressed;

  inst_align #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_data(fetch_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .compressed(compressed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic fv, input logic [31:0] d, input logic [63:0] p,
                     input logic rdy, input logic rd, input logic [63:0] rpc);
    @(negedge clk);
    fetch_valid = fv; fetch_data = d; fetch_pc = p;
    out_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] inst,
                            input logic [63:0] pc, input logic c, input logic fr);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".fready"}, fetch_ready, fr);
    if (v) begin
      chk({tag, ".inst"}, out_inst, inst);
      chk({tag, ".pc"}, out_pc, pc);
      chk({tag, ".c"}, compressed, c);
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; fetch_valid = 1'b1; out_ready = 1'b1; redirect = 1'b0;
    #1;
    chk({tag, ".valid"}, out_valid, 0);
    chk({tag, ".fready"}, fetch_ready, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: a region of halfwords, parsed into an instruction list.
  logic [15:0]     hw [NH];
  logic [63:0]     base;
  int              widx;
  int              idle;
  logic [31:0]     exp_inst [$];
  logic [63:0]     exp_pc   [$];
  logic            exp_c    [$];

  function automatic logic model_rvc(input logic [15:0] h);
`ifdef INST_ALIGN_RVC_EN
    return h[1:0] != 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_region(input logic [63:0] b, input int start_half);
    int i;
    base = b; widx = 0; idle = 0;
    exp_inst.delete(); exp_pc.delete(); exp_c.delete();
    for (int k = 0; k < NH; k++) begin
      hw[k] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) hw[k][1:0] = 2'b11;
    end
    i = start_half;
    while (i < NH) begin
      if (model_rvc(hw[i])) begin
        exp_inst.push_back({16'h0, hw[i]}); exp_pc.push_back(b + 64'(2 * i)); exp_c.push_back(1'b1);
        i += 1;
      end else if (i + 1 < NH) begin
        exp_inst.push_back({hw[i+1], hw[i]}); exp_pc.push_back(b + 64'(2 * i)); exp_c.push_back(1'b0);
        i += 2;
      end else begin
        break;
      end
    end
  endtask

  function automatic logic [63:0] pick_base();
    if ($urandom_range(0, 5) == 0) return 64'hFFFF_FFFF_FFFF_FFE0;
    return 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'h100;
  endfunction

  task automatic do_redirect();
    logic [63:0] nb;
    int rb;
    nb = pick_base();
    rb = $urandom_range(0, 1);
    cyc(1'b1, $urandom, base + 64'(4 * widx), 1'b1, 1'b1, nb + 64'(2 * rb));
    chk("rnd_redir.valid", out_valid, 0);
    chk("rnd_redir.fready", fetch_ready, 0);
`ifdef INST_ALIGN_RVC_EN
    load_region(nb, rb);
`else
    load_region(nb, 0);
`endif
  endtask

  task automatic step();
    logic fv, rdy;
    logic [31:0] wd;
    fv  = (widx < NW) && ($urandom_range(0, 3) != 0);
    rdy = ($urandom_range(0, 2) != 0);
    wd  = (widx < NW) ? {hw[2*widx+1], hw[2*widx]} : 32'h0;
    cyc(fv, wd, base + 64'(4 * widx), rdy, 1'b0, 64'h0);
    if (!fv) chk("rnd_idle.valid", out_valid, 0);
    chk("rnd_fready_needs_fv", fetch_ready & ~fv, 0);
    if (out_valid && !rdy) chk("rnd_bp.fready", fetch_ready, 0);
`ifndef INST_ALIGN_RVC_EN
    chk("rnd_fready_hs", fetch_ready, out_valid & rdy);
`endif
    if (out_valid) begin
      if (exp_inst.size() == 0) begin
        chk("rnd_extra_out", out_valid, 0);
      end else begin
        chk("rnd.inst", out_inst, exp_inst[0]);
        chk("rnd.pc", out_pc, exp_pc[0]);
        chk("rnd.c", compressed, exp_c[0]);
        if (rdy) begin
          void'(exp_inst.pop_front()); void'(exp_pc.pop_front()); void'(exp_c.pop_front());
          idle = 0;
        end
      end
    end
    if (fetch_ready) widx++;
    idle++;
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 32'h0000_0013, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    rst = 1'b1; #1;
    expect_out("reset", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

`ifdef INST_ALIGN_RVC_EN
    cyc(1'b1, 32'h4501_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("two_c.0", 1'b1, 32'h0000_4501, 64'h8000_0000, 1'b1, 1'b0);
    cyc(1'b1, 32'h4501_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("two_c.1", 1'b1, 32'h0000_4501, 64'h8000_0002, 1'b1, 1'b1);

    cyc(1'b1, 32'h0000_0013, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("w32", 1'b1, 32'h0000_0013, 64'h8000_0000, 1'b0, 1'b1);

    cyc(1'b1, 32'h0013_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("strad.lo", 1'b1, 32'h0000_4501, 64'h8000_0000, 1'b1, 1'b0);
    cyc(1'b1, 32'h0013_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("strad.bubble", 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h4501_0000, 64'h8000_0004, 1'b0, 1'b0, 64'h0);
      expect_out("strad.bp", 1'b1, 32'h0000_0013, 64'h8000_0002, 1'b0, 1'b0);
    end
    cyc(1'b1, 32'h4501_0000, 64'h8000_0004, 1'b1, 1'b0, 64'h0);
    expect_out("strad.join", 1'b1, 32'h0000_0013, 64'h8000_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'h4501_0000, 64'h8000_0004, 1'b1, 1'b0, 64'h0);
    expect_out("strad.hi", 1'b1, 32'h0000_4501, 64'h8000_0006, 1'b1, 1'b1);

    cyc(1'b1, 32'h1234_5677, 64'h8000_0008, 1'b1, 1'b1, 64'h8000_0102);
    expect_out("redir_half.cyc", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4501_0000, 64'h8000_0100, 1'b1, 1'b0, 64'h0);
    expect_out("redir_half.out", 1'b1, 32'h0000_4501, 64'h8000_0102, 1'b1, 1'b1);

    cyc(1'b1, 32'h0013_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, 32'h0013_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("rst_mid.bubble", 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
    pulse_reset("rst_mid.rst");
    cyc(1'b1, 32'h0000_0013, 64'h8000_0300, 1'b1, 1'b0, 64'h0);
    expect_out("rst_mid.after", 1'b1, 32'h0000_0013, 64'h8000_0300, 1'b0, 1'b1);

    cyc(1'b1, 32'h0013_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, 32'h0013_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, 32'h9999_9999, 64'h8000_0004, 1'b1, 1'b1, 64'h8000_0200);
    expect_out("redir_mid.cyc", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0013, 64'h8000_0200, 1'b1, 1'b0, 64'h0);
    expect_out("redir_mid.after", 1'b1, 32'h0000_0013, 64'h8000_0200, 1'b0, 1'b1);

    cyc(1'b1, 32'h4501_0000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc(1'b1, 32'h0013_0000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h0);
    expect_out("wrap.bubble", 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0000, 64'h0, 1'b1, 1'b0, 64'h0);
    expect_out("wrap.out", 1'b1, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
`else
    cyc(1'b1, 32'h4501_4501, 64'h8000_0000, 1'b1, 1'b0, 64'h0);
    expect_out("pass.rvc_word", 1'b1, 32'h4501_4501, 64'h8000_0000, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0013, 64'h8000_0004, 1'b1, 1'b0, 64'h0);
    expect_out("pass.w32", 1'b1, 32'h0000_0013, 64'h8000_0004, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h0000_0093, 64'h8000_0008, 1'b0, 1'b0, 64'h0);
      expect_out("pass.bp", 1'b1, 32'h0000_0093, 64'h8000_0008, 1'b0, 1'b0);
    end
    cyc(1'b1, 32'h1234_5677, 64'h8000_000C, 1'b1, 1'b1, 64'h8000_0102);
    expect_out("redir.cyc", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4501_0000, 64'h8000_0100, 1'b1, 1'b0, 64'h0);
    expect_out("redir.after", 1'b1, 32'h4501_0000, 64'h8000_0100, 1'b0, 1'b1);
    pulse_reset("rst_mid.rst");
    cyc(1'b0, 32'h0000_0013, 64'h8000_0300, 1'b1, 1'b0, 64'h0);
    expect_out("idle", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
`endif

    // Randomized streams with redirects and resets
    pulse_reset("rnd_start.rst");
    load_region(64'h8000_0000, 0);
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 199);
      if (exp_inst.size() == 0 || idle > 300) begin
        if (exp_inst.size() != 0) chk("rnd_drain_timeout", 64'(exp_inst.size()), 64'h0);
        do_redirect();
      end else if (r < 3) begin
        do_redirect();
      end else if (r < 4) begin
        pulse_reset("rnd_rst");
        load_region(pick_base(), 0);
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
